// File: rtl/ram_channel_client.sv
// Initiator for the RAM read/write channel pair.
// One CPU load or store at a time, with timeout.
module ram_channel_client #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] rd_address,
  output logic [1:0]  rd_sig_read,
  input  logic [31:0] rd_data,
  input  logic        rd_is_ready,
  output logic [31:0] wr_address,
  output logic [1:0]  wr_sig_write,
  output logic [31:0] wr_data,
  input  logic        wr_is_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);

  state_t      state;
  logic        wr_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [31:0] cnt;
  logic        sel_ready;
  logic        fire;
  logic [31:0] ext;
  logic [31:0] wmask;

  assign sel_ready = wr_q ? wr_is_ready : rd_is_ready;
  assign req_ready = (state == S_IDLE);

  // The strobe must react to is_ready in the same cycle it is sampled.
  assign fire = (state == S_ISSUE) && sel_ready;
  assign rd_sig_read  = (fire && !wr_q) ? size_q : 2'd0;
  assign wr_sig_write = (fire && wr_q) ? size_q : 2'd0;

  // Extend the raw read data according to the latched size.
  always_comb begin
    ext = rd_data;
    case (size_q)
      2'd1: ext = {{24{sgn_q & rd_data[7]}}, rd_data[7:0]};
      2'd2: ext = {{16{sgn_q & rd_data[15]}}, rd_data[15:0]};
      default: ext = rd_data;
    endcase
  end

  // Store data is right-aligned; bits above the size are cleared.
  always_comb begin
    wmask = 32'hFFFF_FFFF;
    case (req_size)
      2'd1: wmask = 32'h0000_00FF;
      2'd2: wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
  end

  // Transaction FSM with registered response and channel address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_q       <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= 2'd0;
      cnt        <= 32'd0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'd0;
      rd_address <= 32'd0;
      wr_address <= 32'd0;
      wr_data    <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q   <= req_write;
            size_q <= req_size;
            sgn_q  <= req_signed;
            if (req_size == 2'd0) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state <= S_ISSUE;
              if (req_write) begin
                wr_address <= req_addr;
                wr_data    <= req_wdata & wmask;
              end else begin
                rd_address <= req_addr;
              end
            end
          end
        end
        S_ISSUE: begin
          if (sel_ready) begin
            state <= S_WAIT;
            cnt   <= 32'd0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 32'd1;
          if (cnt != 32'd0 && sel_ready) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= wr_q ? 32'd0 : ext;
          end else if (TO != 32'd0 && cnt + 32'd1 == TO) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          cnt   <= 32'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_channel_client.sv
// Bench for ram_channel_client with a
// behavioural RAM scheduler responder.
module tb_ram_channel_client;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] rd_address;
  logic [1:0]  rd_sig_read;
  logic [31:0] rd_data;
  logic        rd_is_ready;
  logic [31:0] wr_address;
  logic [1:0]  wr_sig_write;
  logic [31:0] wr_data;
  logic        wr_is_ready;

  int checks = 0;
  int errors = 0;

  // RAM model controls
  int          busy_cfg = 0;
  logic        hang = 1'b0;
  logic        blk = 1'b0;
  logic [31:0] rd_value = 32'd0;

  // RAM model state
  logic        rd_rdy_q, wr_rdy_q;
  int          rd_left, wr_left;
  logic [31:0] rd_q;
  logic [31:0] cap_addr, cap_wdata;
  logic [1:0]  cap_size;
  int rd_strobes = 0;
  int wr_strobes = 0;
  int bad_strobes = 0;
  int resp_count = 0;

  always #5 clk = ~clk;

  ram_channel_client #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_error(resp_error),
    .resp_rdata(resp_rdata),
    .rd_address(rd_address),
    .rd_sig_read(rd_sig_read),
    .rd_data(rd_data),
    .rd_is_ready(rd_is_ready),
    .wr_address(wr_address),
    .wr_sig_write(wr_sig_write),
    .wr_data(wr_data),
    .wr_is_ready(wr_is_ready)
  );

  assign rd_is_ready = rd_rdy_q && !blk;
  assign wr_is_ready = wr_rdy_q && !blk;
  assign rd_data = rd_q;

  // Read responder: busy for busy_cfg+1 cycles after a take.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_rdy_q <= 1'b1;
      rd_left  <= 0;
      rd_q     <= 32'd0;
    end else if (rd_sig_read != 2'd0 && rd_is_ready) begin
      rd_rdy_q <= 1'b0;
      rd_left  <= busy_cfg;
      cap_addr <= rd_address;
      cap_size <= rd_sig_read;
    end else if (!rd_rdy_q && !hang) begin
      if (rd_left == 0) begin
        rd_rdy_q <= 1'b1;
        rd_q     <= rd_value;
      end else begin
        rd_left <= rd_left - 1;
      end
    end
  end

  // Write responder, same timing as the read side.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_rdy_q <= 1'b1;
      wr_left  <= 0;
    end else if (wr_sig_write != 2'd0 && wr_is_ready) begin
      wr_rdy_q  <= 1'b0;
      wr_left   <= busy_cfg;
      cap_addr  <= wr_address;
      cap_size  <= wr_sig_write;
      cap_wdata <= wr_data;
    end else if (!wr_rdy_q && !hang) begin
      if (wr_left == 0) wr_rdy_q <= 1'b1;
      else wr_left <= wr_left - 1;
    end
  end

  // Protocol monitors
  always @(posedge clk) begin
    if (rd_sig_read != 2'd0) rd_strobes <= rd_strobes + 1;
    if (wr_sig_write != 2'd0) wr_strobes <= wr_strobes + 1;
    if ((rd_sig_read != 2'd0 && !rd_is_ready) ||
        (wr_sig_write != 2'd0 && !wr_is_ready))
      bad_strobes <= bad_strobes + 1;
    if (resp_valid) resp_count <= resp_count + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(
      input logic [1:0] sz, input logic sg, input logic [31:0] v);
    logic [31:0] e;
    e = v;
    if (sz == 2'd1) begin
      e = v % 256;
      if (sg && e >= 128) e = e - 256;
    end else if (sz == 2'd2) begin
      e = v % 65536;
      if (sg && e >= 32768) e = e - 65536;
    end
    return e;
  endfunction

  task automatic run_txn(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rv,
                         input int b, input int s);
    int n;
    int rs0, ws0;
    logic got;
    logic [31:0] e, mask;
    busy_cfg = b;
    rd_value = rv;
    rs0 = rd_strobes;
    ws0 = wr_strobes;
    blk = (s > 0);
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    for (int i = 0; i < s; i++) begin
      chk("stall_strobe",
          32'(w ? wr_sig_write : rd_sig_read), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    blk = 1'b0;
    if (s > 0) begin
      #1;
      chk("strobe_after_stall",
          32'(w ? wr_sig_write : rd_sig_read), 32'(sz));
    end
    got = 1'b0;
    while (!got && n < 60) begin
      if (resp_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    if (sz == 2'd0 || w) e = 32'd0;
    else e = model_load(sz, sg, rv);
    if (got) begin
      chk("resp_error", 32'(resp_error), 32'(sz == 2'd0));
      chk("resp_rdata", resp_rdata, e);
      chk("req_ready_resp", 32'(req_ready), 32'd0);
      if (sz == 2'd0) chk("latency_err", 32'(n <= 2), 32'd1);
      else chk("latency", 32'(n), 32'(4 + b + s));
    end
    chk("rd_strobe_cycles", 32'(rd_strobes - rs0),
        32'(!w && sz != 2'd0));
    chk("wr_strobe_cycles", 32'(wr_strobes - ws0),
        32'(w && sz != 2'd0));
    if (sz != 2'd0) begin
      chk("chan_addr", cap_addr, a);
      chk("chan_size", 32'(cap_size), 32'(sz));
      if (w) begin
        mask = (sz == 2'd3) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
        chk("chan_wdata", cap_wdata, wd & mask);
      end
    end
    @(posedge clk); #1;
    chk("resp_valid_pulse", 32'(resp_valid), 32'd0);
    chk("resp_error_clr", 32'(resp_error), 32'd0);
    chk("resp_rdata_hold", resp_rdata, e);
  endtask

  initial begin
    int n, pc0;
    logic [1:0] sz;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_rd_sig", 32'(rd_sig_read), 32'd0);
    chk("rst_wr_sig", 32'(wr_sig_write), 32'd0);
    chk("rst_rd_addr", rd_address, 32'd0);
    chk("rst_wr_addr", wr_address, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 3, 0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h3, 32'd0, 32'h000000F0, 1, 0);
    run_txn(1'b0, 2'd1, 1'b0, 32'h3, 32'd0, 32'h000000F0, 1, 0);
    run_txn(1'b0, 2'd2, 1'b1, 32'h2, 32'd0, 32'h12348001, 0, 0);
    run_txn(1'b1, 2'd2, 1'b0, 32'h6, 32'h12345678, 32'd0, 2, 0);
    run_txn(1'b1, 2'd1, 1'b0, 32'h9, 32'hCAFEF00D, 32'd0, 1, 5);
    run_txn(1'b0, 2'd0, 1'b1, 32'h40, 32'd0, 32'h55, 0, 0);
    run_txn(1'b1, 2'd0, 1'b0, 32'h44, 32'hFFFF, 32'h0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      sz = 2'($urandom_range(1, 3));
      run_txn(1'($urandom_range(0, 1)), sz,
              1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
    end

    // RAM never completes: timeout after 8 WAIT cycles
    hang = 1'b1;
    busy_cfg = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = 2'd3;
    req_addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_seen", 32'(resp_valid), 32'd1);
    chk("to_latency", 32'(n), 32'd10);
    chk("to_error", 32'(resp_error), 32'd1);
    chk("to_rdata", resp_rdata, 32'd0);
    hang = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("to_idle", 32'(req_ready), 32'd1);

    // Reset in the middle of WAIT
    run_txn(1'b0, 2'd3, 1'b0, 32'h300, 32'd0, 32'h0BADF00D, 0, 0);
    hang = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'd2;
    req_addr = 32'h304;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(req_ready), 32'd0);
    pc0 = resp_count;
    reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'd0);
    chk("mid_rst_rd_sig", 32'(rd_sig_read), 32'd0);
    chk("mid_rst_wr_sig", 32'(wr_sig_write), 32'd0);
    chk("mid_rst_wr_addr", wr_address, 32'd0);
    chk("mid_rst_rd_addr", rd_address, 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    hang = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_resp_after_rst", 32'(resp_count - pc0), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    run_txn(1'b0, 2'd2, 1'b1, 32'h7, 32'd0, 32'h0000FFFE, 2, 1);

    chk("protocol_strobe_when_busy", 32'(bad_strobes), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
